servo_pwm_bank: RTL and testbench
=================================

# servo_pwm_bank

Eight-channel servo pulse generator sitting directly downstream of the move translator. It takes the per-servo position bits the translator drives and produces one hobby-servo PWM waveform per servo: four linear (forward/back) and four rotary (rest/ccw). Command changes take effect only on frame boundaries, so outputs never glitch. A `busy` flag tells the translator when the mechanism has had time to settle.

## Interface
- `PERIOD_CYC`, default 1_000_000: frame length in clk cycles (20 ms at 50 MHz).
- `LIN_BACK_CYC`, default 50_000: pulse width for linear servo position "back" (1.0 ms).
- `LIN_FWD_CYC`, default 100_000: pulse width for linear servo position "forward" (2.0 ms).
- `ROT_REST_CYC`, default 75_000: pulse width for rotary servo position "resting" (1.5 ms).
- `ROT_CCW_CYC`, default 100_000: pulse width for rotary servo position "ccw" (+90°).
- `SETTLE_FRAMES`, default 25: frames `busy` stays high after a change (0.5 s).
- `clk` in 1: system clock.
- `rst` in 1: reset. Asynchronous, active-low.
- `lin_cmd` in 4: linear position per servo, indexed [0]=left, [1]=right, [2]=top, [3]=bottom. 1 = forward, 0 = back.
- `rot_cmd` in 4: rotary position, same indexing. 1 = ccw, 0 = resting.
- `out_en` in 1: when low, all pulses are suppressed (servos limp).
- `pwm_lin` out 4: PWM outputs for the linear servos.
- `pwm_rot` out 4: PWM outputs for the rotary servos.
- `frame_tick` out 1: one-cycle pulse on the last cycle of each frame.
- `busy` out 1: high while the servos are settling.

## Operation
- `frame_cnt` counts 0..PERIOD_CYC-1 and wraps to 0. Width is $clog2(PERIOD_CYC).
- **Shadow latch.** On the cycle `frame_cnt == PERIOD_CYC-1`, the block samples `lin_cmd`, `rot_cmd` and `out_en` into shadow registers. Only the shadow registers drive the PWM. Mid-frame input changes have no effect until the next boundary.
- **Width select.** Each channel's width is the LIN or ROT constant selected by its shadow bit.
- **Output rule.** `pwm[i]` is registered as `shadow_en && (frame_cnt_next < width[i])`.
- **Settle counter.**
  - At each boundary, if the newly sampled {lin,rot} differs from the previous shadow value, or `out_en` rises 0→1, `settle_cnt` loads SETTLE_FRAMES.
  - Otherwise, if `settle_cnt` is nonzero, it decrements by 1.
  - `busy = (settle_cnt != 0)`, registered.
- **Reset values.**
  - `frame_cnt` = 0; shadow `lin` = 4'b1111; shadow `rot` = 4'b0000; shadow `en` = 0.
  - `settle_cnt` = SETTLE_FRAMES.
  - Outputs: `pwm_lin` = 0, `pwm_rot` = 0, `frame_tick` = 0, `busy` = 1.
- **Reset mid-frame.** Outputs drop to 0 immediately (asynchronously). The frame restarts at 0 on the first clk after release.
- **Legality.** Every width constant must satisfy 0 < width < PERIOD_CYC. SETTLE_FRAMES must be ≥ 1. Both are checked by elaboration-time assertions.

## Timing
- `frame_tick` is high on the cycle where `frame_cnt == PERIOD_CYC-1`.
- Pulses start the cycle after `frame_tick` and stay high for exactly `width` cycles. Period is exactly PERIOD_CYC cycles.
- Command latency is 1 to PERIOD_CYC cycles. A command present on the `frame_tick` cycle appears in the very next frame.
- `busy` rises the cycle after the `frame_tick` on which a change was sampled. It falls the cycle after the SETTLE_FRAMES-th following `frame_tick`.
- If a change and an in-progress settle coincide, the counter reloads. Settling extends; it never stacks.
- If `out_en` is low, `busy` still counts down after a change, while pulses stay low.

## Structure
- Package `servo_pkg` holds:
  - channel index constants LEFT=0, RIGHT=1, TOP=2, BOTTOM=3;
  - position encodings POS_FORWARD/POS_BACK and ROT_CCW/ROT_REST;
  - default width constants, shared with the translator.
- Sub-module `servo_pwm_channel`: shadow bit, width mux and compare register. It takes two width parameters and is instantiated 8 times. The frame counter, settle logic and `busy` live in the top.

## Test plan
Simulation parameters: PERIOD_CYC=100, LIN_BACK=5, LIN_FWD=10, ROT_REST=7, ROT_CCW=12, SETTLE_FRAMES=2.
- **Reset release, out_en=1, lin_cmd=4'hF, rot_cmd=0.**
  - Frame 0: all PWM low (shadow `en`=0), `busy`=1.
  - From frame 1: `pwm_lin` 10 cycles high per 100, `pwm_rot` 7 cycles high.
  - `busy` clears after 2 ticks.
- **lin_cmd[2] 1→0 at cycle 40 of a frame.** Current frame is unchanged. Next frame `pwm_lin[2]` is 5 cycles high. `busy` is high for exactly 2 frames.
- **rot_cmd toggled at cycles 30 and 60 of one frame (net no change).** No width change and `busy` stays low.
- **Change sampled while `settle_cnt`=1.** Counter reloads to 2 and `busy` stays continuously high for 2 further frames.
- **Assert `rst` low at cycle 8 of a pulse.** All PWM outputs go low within the same cycle, without a clk edge. After release, `pwm_lin` returns to the 4'b1111 reset defaults.
- **out_en dropped mid-frame.** Pulses continue to the boundary, then stay 0. Re-enabling restarts pulses next frame and sets `busy` for 2 frames.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: constants shared by the servo PWM bank and the move translator.
//   - channel indices (which servo sits on which bit of lin/rot vectors)
//   - position encodings for linear and rotary servos
//   - default timing constants in clk cycles at 50 MHz
package servo_pkg;

  localparam int NUM_CH = 4;

  // Bit positions within lin_cmd / rot_cmd / pwm_lin / pwm_rot.
  localparam int LEFT   = 0;
  localparam int RIGHT  = 1;
  localparam int TOP    = 2;
  localparam int BOTTOM = 3;

  // Linear servo: 1 = forward, 0 = back.
  localparam logic POS_FORWARD = 1'b1;
  localparam logic POS_BACK    = 1'b0;

  // Rotary servo: 1 = ccw (+90 deg), 0 = resting.
  localparam logic ROT_CCW  = 1'b1;
  localparam logic ROT_REST = 1'b0;

  // Default timing (50 MHz clock).
  localparam int DEF_PERIOD_CYC    = 1_000_000; // 20 ms frame
  localparam int DEF_LIN_BACK_CYC  = 50_000;    // 1.0 ms
  localparam int DEF_LIN_FWD_CYC   = 100_000;   // 2.0 ms
  localparam int DEF_ROT_REST_CYC  = 75_000;    // 1.5 ms
  localparam int DEF_ROT_CCW_CYC   = 100_000;   // +90 deg
  localparam int DEF_SETTLE_FRAMES = 25;        // 0.5 s

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo output.
//   Holds the frame-latched command bit (shadow), selects the pulse width
//   from it and registers the PWM compare.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   tick         high on the last cycle of the frame (shadow load strobe)
//   cmd          live command bit from the translator
//   en_next      output enable as it will be in the coming cycle
//   cnt_next     frame counter value of the coming cycle
//   shadow       latched command bit (used by the top for change detection)
//   pwm          registered PWM output
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int   CW       = 20,
  parameter int   WIDTH_LO = 1,    // width when the shadow bit is 0
  parameter int   WIDTH_HI = 2,    // width when the shadow bit is 1
  parameter logic RST_BIT  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          cmd,
  input  logic          en_next,
  input  logic [CW-1:0] cnt_next,
  output logic          shadow,
  output logic          pwm
);

  localparam logic [CW-1:0] W_LO = CW'(WIDTH_LO);
  localparam logic [CW-1:0] W_HI = CW'(WIDTH_HI);

  logic          shadow_next;
  logic [CW-1:0] width;

  // The compare uses the value the shadow is about to take, so a command
  // sampled on the tick cycle already shapes the first pulse of the new frame.
  assign shadow_next = tick ? cmd : shadow;
  assign width       = shadow_next ? W_HI : W_LO;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= RST_BIT;
      pwm    <= 1'b0;
    end else begin
      shadow <= shadow_next;
      pwm    <= en_next && (cnt_next < width);
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: eight hobby-servo PWM generators (4 linear, 4 rotary).
//   Commands are latched only at frame boundaries so pulses never glitch;
//   busy stays high for SETTLE_FRAMES frames after any latched change.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   lin_cmd[4]   linear positions (1 forward, 0 back), [0]=left..[3]=bottom
//   rot_cmd[4]   rotary positions (1 ccw, 0 resting), same indexing
//   out_en       0 suppresses all pulses (latched at frame boundary)
//   pwm_lin[4]   linear servo PWM outputs
//   pwm_rot[4]   rotary servo PWM outputs
//   frame_tick   high on the last cycle of each frame
//   busy         high while the mechanism is settling
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC    = DEF_PERIOD_CYC,
  parameter int LIN_BACK_CYC  = DEF_LIN_BACK_CYC,
  parameter int LIN_FWD_CYC   = DEF_LIN_FWD_CYC,
  parameter int ROT_REST_CYC  = DEF_ROT_REST_CYC,
  parameter int ROT_CCW_CYC   = DEF_ROT_CCW_CYC,
  parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] lin_cmd,
  input  logic [NUM_CH-1:0] rot_cmd,
  input  logic              out_en,
  output logic [NUM_CH-1:0] pwm_lin,
  output logic [NUM_CH-1:0] pwm_rot,
  output logic              frame_tick,
  output logic              busy
);

  localparam int CW = $clog2(PERIOD_CYC);
  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam logic [CW-1:0] LAST_CNT    = CW'(PERIOD_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_FRAMES);

  // Elaboration-time legality checks.
  if (LIN_BACK_CYC <= 0 || LIN_BACK_CYC >= PERIOD_CYC) begin : g_bad_lin_back
    $error("LIN_BACK_CYC must be in 1..PERIOD_CYC-1");
  end
  if (LIN_FWD_CYC <= 0 || LIN_FWD_CYC >= PERIOD_CYC) begin : g_bad_lin_fwd
    $error("LIN_FWD_CYC must be in 1..PERIOD_CYC-1");
  end
  if (ROT_REST_CYC <= 0 || ROT_REST_CYC >= PERIOD_CYC) begin : g_bad_rot_rest
    $error("ROT_REST_CYC must be in 1..PERIOD_CYC-1");
  end
  if (ROT_CCW_CYC <= 0 || ROT_CCW_CYC >= PERIOD_CYC) begin : g_bad_rot_ccw
    $error("ROT_CCW_CYC must be in 1..PERIOD_CYC-1");
  end
  if (SETTLE_FRAMES < 1) begin : g_bad_settle
    $error("SETTLE_FRAMES must be at least 1");
  end

  logic [CW-1:0]     frame_cnt;
  logic [CW-1:0]     frame_cnt_next;
  logic              tick;
  logic              shadow_en;
  logic              en_next;
  logic [NUM_CH-1:0] lin_sh;
  logic [NUM_CH-1:0] rot_sh;
  logic              change;
  logic [SW-1:0]     settle_cnt;
  logic [SW-1:0]     settle_next;

  assign tick           = (frame_cnt == LAST_CNT);
  assign frame_tick     = tick;
  assign frame_cnt_next = tick ? '0 : frame_cnt + CW'(1);
  assign en_next        = tick ? out_en : shadow_en;

  // A disable (1->0) alone is not a change: the servos simply go limp.
  assign change = tick && (({lin_cmd, rot_cmd} != {lin_sh, rot_sh}) ||
                           (out_en && !shadow_en));

  // Reload on change (extends, never stacks); otherwise count frames down.
  always_comb begin
    settle_next = settle_cnt;
    if (change) begin
      settle_next = SETTLE_LOAD;
    end else if (tick && settle_cnt != '0) begin
      settle_next = settle_cnt - SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt  <= '0;
      shadow_en  <= 1'b0;
      settle_cnt <= SETTLE_LOAD;
      busy       <= 1'b1;
    end else begin
      frame_cnt  <= frame_cnt_next;
      shadow_en  <= en_next;
      settle_cnt <= settle_next;
      busy       <= (settle_next != '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .CW       (CW),
      .WIDTH_LO (LIN_BACK_CYC),
      .WIDTH_HI (LIN_FWD_CYC),
      .RST_BIT  (POS_FORWARD)
    ) u_lin (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .cmd      (lin_cmd[i]),
      .en_next  (en_next),
      .cnt_next (frame_cnt_next),
      .shadow   (lin_sh[i]),
      .pwm      (pwm_lin[i])
    );

    servo_pwm_channel #(
      .CW       (CW),
      .WIDTH_LO (ROT_REST_CYC),
      .WIDTH_HI (ROT_CCW_CYC),
      .RST_BIT  (ROT_REST)
    ) u_rot (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .cmd      (rot_cmd[i]),
      .en_next  (en_next),
      .cnt_next (frame_cnt_next),
      .shadow   (rot_sh[i]),
      .pwm      (pwm_rot[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: self-checking bench for servo_pwm_bank with small
// timing parameters. A frame-level model (position within frame, frame
// number, commands latched per frame, frame of last change) predicts every
// output each cycle; literal pins anchor the model to hand-derived values.
module tb_servo_pwm_bank;

  localparam int P  = 100;
  localparam int LB = 5;
  localparam int LF = 10;
  localparam int RR = 7;
  localparam int RC = 12;
  localparam int S  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] lin_cmd = 4'hF;
  logic [3:0] rot_cmd = 4'h0;
  logic       out_en = 1'b1;
  logic [3:0] pwm_lin;
  logic [3:0] pwm_rot;
  logic       frame_tick;
  logic       busy;

  servo_pwm_bank #(
    .PERIOD_CYC    (P),
    .LIN_BACK_CYC  (LB),
    .LIN_FWD_CYC   (LF),
    .ROT_REST_CYC  (RR),
    .ROT_CCW_CYC   (RC),
    .SETTLE_FRAMES (S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lin_cmd    (lin_cmd),
    .rot_cmd    (rot_cmd),
    .out_en     (out_en),
    .pwm_lin    (pwm_lin),
    .pwm_rot    (pwm_rot),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int         m_pos   = 0;   // cycle within frame
  int         m_frame = 0;   // frames since reset release
  int         m_last  = 0;   // frame in which the last change took effect
  logic [3:0] m_lin   = 4'hF;
  logic [3:0] m_rot   = 4'h0;
  logic       m_en    = 1'b0;
  logic       chk_on  = 1'b0;

  int total = 0;
  int bad   = 0;

  // {frame_tick, busy, pwm_rot, pwm_lin}
  logic [9:0] exp_q[$];

  function automatic logic [9:0] exp_vec();
    logic [3:0] l;
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      l[i] = m_en && (m_pos < (m_lin[i] ? LF : LB));
      r[i] = m_en && (m_pos < (m_rot[i] ? RC : RR));
    end
    return {(m_pos == P - 1), ((m_frame - m_last) < S), r, l};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s frame=%0d pos=%0d got=%0h want=%0h", name, m_frame, m_pos, act, exp);
    end
  endtask

  // Model: advances one cycle per clock, restarts on reset.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_pos = 0; m_frame = 0; m_last = 0;
        m_lin = 4'hF; m_rot = 4'h0; m_en = 1'b0;
        exp_q.delete();
      end else if (m_pos == P - 1) begin
        logic chg;
        chg = ({lin_cmd, rot_cmd} != {m_lin, m_rot}) || (out_en && !m_en);
        m_lin = lin_cmd; m_rot = rot_cmd; m_en = out_en;
        m_frame++;
        m_pos = 0;
        if (chg) m_last = m_frame;
      end else begin
        m_pos++;
      end
      exp_q.push_back(exp_vec());
    end
  end

  // Scoreboard: compare every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL exp_q_empty frame=%0d pos=%0d got=none want=entry", m_frame, m_pos);
        end else begin
          logic [9:0] v;
          v = exp_q.pop_front();
          check("pwm_lin", 32'(pwm_lin), 32'(v[3:0]));
          check("pwm_rot", 32'(pwm_rot), 32'(v[7:4]));
          check("busy", 32'(busy), 32'(v[8]));
          check("frame_tick", 32'(frame_tick), 32'(v[9]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Wait until the falling edge of (frame f, position p), bounded.
  task automatic wait_at(input int f, input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_frame == f && m_pos == p) && n < 3000);
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL wait_at timeout got=frame%0d/pos%0d want=frame%0d/pos%0d", m_frame, m_pos, f, p);
    end
  endtask

  task automatic pin(input string name, input int f, input int p, input logic [31:0] act_sel,
                     input logic [31:0] exp);
    check($sformatf("%s@%0d.%0d", name, f, p), act_sel, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Reset release, enable on: frame 0 silent, then 10/7-cycle pulses.
    wait_at(0, 50); pin("f0_lin", 0, 50, 32'(pwm_lin), 0); pin("f0_busy", 0, 50, 32'(busy), 1);
    wait_at(1, 6);  pin("rot_w6", 1, 6, 32'(pwm_rot), 32'hF);
    wait_at(1, 7);  pin("rot_w7", 1, 7, 32'(pwm_rot), 0);
    wait_at(1, 9);  pin("lin_w9", 1, 9, 32'(pwm_lin), 32'hF);
    wait_at(1, 10); pin("lin_w10", 1, 10, 32'(pwm_lin), 0);
    wait_at(2, 50); pin("busy_f2", 2, 50, 32'(busy), 1);
    wait_at(3, 50); pin("busy_f3", 3, 50, 32'(busy), 0);

    // lin_cmd[2] forward->back mid-frame.
    wait_at(4, 40); #2 lin_cmd = 4'b1011;
    wait_at(5, 4);  pin("lin2_w4", 5, 4, 32'(pwm_lin), 32'hF);
    wait_at(5, 5);  pin("lin2_w5", 5, 5, 32'(pwm_lin), 32'b1011);
    wait_at(6, 50); pin("busy_f6", 6, 50, 32'(busy), 1);
    wait_at(7, 50); pin("busy_f7", 7, 50, 32'(busy), 0);

    // Rotary toggled and restored inside one frame: no visible effect.
    wait_at(8, 30); #2 rot_cmd = 4'b0010;
    wait_at(8, 60); #2 rot_cmd = 4'b0000;
    wait_at(9, 7);  pin("rot_nochg", 9, 7, 32'(pwm_rot), 0);
    wait_at(9, 50); pin("busy_nochg", 9, 50, 32'(busy), 0);

    // Change sampled while one settle frame remains: reload.
    wait_at(10, 20); #2 lin_cmd = 4'b1111;
    wait_at(12, 20); #2 lin_cmd = 4'b0111;
    wait_at(14, 50); pin("busy_ext", 14, 50, 32'(busy), 1);
    wait_at(15, 50); pin("busy_ext_end", 15, 50, 32'(busy), 0);
    #2 lin_cmd = 4'hF; rot_cmd = 4'hF;

    // Asynchronous reset in the middle of a pulse.
    wait_at(16, 8);
    pin("pre_rst_lin", 16, 8, 32'(pwm_lin), 32'hF);
    pin("pre_rst_rot", 16, 8, 32'(pwm_rot), 32'hF);
    #2 rst = 1'b0;
    #1;
    check("async_lin", 32'(pwm_lin), 0);
    check("async_rot", 32'(pwm_rot), 0);
    check("async_busy", 32'(busy), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    wait_at(1, 9); pin("post_rst_lin", 1, 9, 32'(pwm_lin), 32'hF);

    // out_en dropped mid-frame, then re-enabled.
    wait_at(3, 5);  #2 out_en = 1'b0;
    wait_at(3, 8);  pin("dis_cont", 3, 8, 32'(pwm_lin), 32'hF);
    wait_at(4, 8);  pin("dis_lin", 4, 8, 32'(pwm_lin), 0);
    pin("dis_rot", 4, 8, 32'(pwm_rot), 0);
    wait_at(4, 50); pin("dis_busy", 4, 50, 32'(busy), 0);
    #2 out_en = 1'b1;
    wait_at(5, 8);  pin("reen_lin", 5, 8, 32'(pwm_lin), 32'hF);
    wait_at(6, 50); pin("reen_busy", 6, 50, 32'(busy), 1);
    wait_at(7, 50); pin("reen_busy_end", 7, 50, 32'(busy), 0);

    // Randomized commands at random points, including the tick cycle.
    for (int f = 8; f < 30; f++) begin
      int p;
      p = ($urandom_range(0, 2) == 0) ? P - 1 : $urandom_range(1, 97);
      wait_at(f, p);
      #2;
      if ($urandom_range(0, 1) == 0) lin_cmd = 4'($urandom);
      if ($urandom_range(0, 2) == 0) rot_cmd = 4'($urandom);
      out_en = ($urandom_range(0, 4) != 0);
    end
    wait_at(31, 50);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
